// File: rtl/reg_arb_mux_pkg.sv
// Shared constants for the registered N:1 arbitrating mux.
//   MODE_SELECT / MODE_RR : values of the mode input
//   DEF_WIDTH / DEF_CHANNELS : default datapath geometry
package reg_arb_mux_pkg;
  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 8;
endpackage

// File: rtl/reg_arb_mux_rr_pick.sv
// rr_pick: combinational circular search of a valid vector.
//   valid [CHANNELS] : request vector
//   start [SEL_W]    : first index to examine (must be < CHANNELS)
//   found            : some bit of valid is set
//   idx   [SEL_W]    : first set index at or after start, wrapping to 0
module rr_pick #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SEL_W-1:0]    start,
  output logic                found,
  output logic [SEL_W-1:0]    idx
);
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      j = int'(start) + k;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = SEL_W'(j);
      end
    end
  end
endmodule

// File: rtl/reg_arb_mux.sv
// reg_arb_mux: registered CHANNELS:1 word mux with valid/ready handshakes.
// Picks a channel by explicit select (mode=0) or round-robin (mode=1) and
// holds the result in a single output register stage.
//   clk, rst_n        : clock, synchronous active-low reset
//   enable            : low flushes the output register and blocks traffic
//   mode, sel         : selection policy and direct-select index
//   in_data/in_valid  : packed channel words and their valids
//   in_ready          : one-hot (or zero) accept back to producers
//   out_data/out_ch   : registered word and the channel that supplied it
//   out_valid/out_ready : output handshake
//   out_parity        : even parity of out_data (only with REG_ARB_MUX_PARITY_EN)
module reg_arb_mux
  import reg_arb_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef REG_ARB_MUX_PARITY_EN
  , output logic                    out_parity
`endif
);
  localparam int EXT = 1 << SEL_W;

  logic [CHANNELS-1:0][WIDTH-1:0] din;
  logic [EXT-1:0]                 valid_ext;
  logic [SEL_W-1:0]               rr_ptr;
  logic                           rr_found, has_cand, load, grant;
  logic [SEL_W-1:0]               rr_idx, cand;

  assign din = in_data;
  // Zero-extend so any sel value indexes safely; selects past CHANNELS see 0.
  assign valid_ext = EXT'(in_valid);

  rr_pick #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_pick (
    .valid (in_valid),
    .start (rr_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    cand     = '0;
    has_cand = 1'b0;
    if (mode == MODE_RR) begin
      cand     = rr_idx;
      has_cand = rr_found;
    end else begin
      cand     = sel;
      has_cand = valid_ext[sel];
    end
  end

  // rst_n gates load so no producer sees an accept while reset is held.
  assign load  = rst_n && enable && (!out_valid || out_ready);
  assign grant = load && has_cand;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++)
      in_ready[i] = grant && (cand == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (!enable) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= has_cand;
      if (has_cand) begin
        out_data <= din[cand];
        out_ch   <= cand;
        if (mode == MODE_RR)
          rr_ptr <= (cand == SEL_W'(CHANNELS-1)) ? '0 : cand + 1'b1;
      end
    end
  end

`ifdef REG_ARB_MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) out_parity <= 1'b0;
    else if (grant)        out_parity <= ^din[cand];
  end
`endif
endmodule

// File: tb/tb_reg_arb_mux.sv
module tb_reg_arb_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // shared controls
  logic rst_n, enable, out_ready;

  // 8-channel instance
  logic          a_mode;
  logic [2:0]    a_sel;
  logic [127:0]  a_data;
  logic [7:0]    a_valid, a_ready;
  logic [15:0]   a_odata;
  logic [2:0]    a_och;
  logic          a_ovalid;

  // 5-channel instance
  logic          b_mode;
  logic [2:0]    b_sel;
  logic [79:0]   b_data;
  logic [4:0]    b_valid, b_ready;
  logic [15:0]   b_odata;
  logic [2:0]    b_och;
  logic          b_ovalid;
`ifdef REG_ARB_MUX_PARITY_EN
  logic a_par, b_par;
`endif

  reg_arb_mux #(.WIDTH(16), .CHANNELS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(a_mode), .sel(a_sel),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_data(a_odata), .out_ch(a_och), .out_valid(a_ovalid), .out_ready(out_ready)
`ifdef REG_ARB_MUX_PARITY_EN
    , .out_parity(a_par)
`endif
  );

  reg_arb_mux #(.WIDTH(16), .CHANNELS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(b_mode), .sel(b_sel),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_data(b_odata), .out_ch(b_och), .out_valid(b_ovalid), .out_ready(out_ready)
`ifdef REG_ARB_MUX_PARITY_EN
    , .out_parity(b_par)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] word(input int c);
    return (c == 3) ? 16'hBEEF : 16'hA000 + 16'(c);
  endfunction

  initial begin
    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
    a_mode = 1'b0; a_sel = 3'd0; a_valid = 8'hFF;
    for (int i = 0; i < 8; i++) a_data[i*16 +: 16] = word(i);
    b_mode = 1'b0; b_sel = 3'd0; b_valid = 5'd0;
    for (int i = 0; i < 5; i++) b_data[i*16 +: 16] = 16'hB000 + 16'(i);

    // reset state
    #1;
    chk("rst_in_ready", 32'(a_ready), 32'h0);
    step(); step();
    chk("rst_valid", 32'(a_ovalid), 32'h0);
    chk("rst_data",  32'(a_odata),  32'h0);
    chk("rst_ch",    32'(a_och),    32'h0);
    chk("rst_b_valid", 32'(b_ovalid), 32'h0);
`ifdef REG_ARB_MUX_PARITY_EN
    chk("rst_par", 32'(a_par), 32'h0);
`endif

    // direct select
    rst_n = 1'b1; a_sel = 3'd3; a_valid = 8'h08;
    #1;
    chk("sel_ready", 32'(a_ready), 32'h08);
    step();
    chk("sel_valid", 32'(a_ovalid), 32'h1);
    chk("sel_data",  32'(a_odata),  32'hBEEF);
    chk("sel_ch",    32'(a_och),    32'h3);
`ifdef REG_ARB_MUX_PARITY_EN
    chk("sel_par", 32'(a_par), 32'h1);
`endif

    // selected channel not valid: output drops, data/ch hold
    a_sel = 3'd5;
    #1;
    chk("nocand_ready", 32'(a_ready), 32'h0);
    step();
    chk("nocand_valid", 32'(a_ovalid), 32'h0);
    chk("nocand_data",  32'(a_odata),  32'hBEEF);
    chk("nocand_ch",    32'(a_och),    32'h3);

    // round-robin fairness: pointer still 0 after direct-select grants
    a_mode = 1'b1; a_valid = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("rr_ready", 32'(a_ready), 32'(8'h01 << (i % 8)));
      step();
      chk("rr_ch",   32'(a_och),   32'(i % 8));
      chk("rr_data", 32'(a_odata), 32'(word(i % 8)));
      chk("rr_valid", 32'(a_ovalid), 32'h1);
    end

    // backpressure holding channel 1
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(a_ready), 32'h0);
      step();
      chk("bp_ch",   32'(a_och),   32'h1);
      chk("bp_data", 32'(a_odata), 32'(word(1)));
      chk("bp_valid", 32'(a_ovalid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(a_ready), 32'h04);
    step();
    chk("bp_resume_ch", 32'(a_och), 32'h2);

    // enable low discards a pending 16'h1234 (rr_ptr stays 3 in mode 0)
    a_mode = 1'b0; a_sel = 3'd4; a_valid = 8'h10; a_data[4*16 +: 16] = 16'h1234;
    step();
    chk("en_pre_data", 32'(a_odata), 32'h1234);
    chk("en_pre_ch",   32'(a_och),   32'h4);
    out_ready = 1'b0; enable = 1'b0;
    #1;
    chk("en_low_ready", 32'(a_ready), 32'h0);
    step();
    chk("en_low_valid", 32'(a_ovalid), 32'h0);
    chk("en_low_data",  32'(a_odata),  32'h0);
    chk("en_low_ch",    32'(a_och),    32'h0);
`ifdef REG_ARB_MUX_PARITY_EN
    chk("en_low_par", 32'(a_par), 32'h0);
`endif
    enable = 1'b1; out_ready = 1'b1; a_sel = 3'd0; a_valid = 8'h00;
    #1;
    chk("en_idle_ready", 32'(a_ready), 32'h0);
    step();
    chk("en_idle_valid", 32'(a_ovalid), 32'h0);

    // reset mid-stream
    a_mode = 1'b1; a_valid = 8'hFF;
    step();
    chk("mid_ch", 32'(a_och), 32'h3);
    a_valid = 8'hA4; a_data[2*16 +: 16] = 16'h0007;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(a_ready), 32'h0);
    step();
    chk("mid_rst_valid", 32'(a_ovalid), 32'h0);
    chk("mid_rst_data",  32'(a_odata),  32'h0);
    chk("mid_rst_ch",    32'(a_och),    32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(a_ready), 32'h04);
    step();
    chk("post_rst_ch",   32'(a_och),   32'h2);
    chk("post_rst_data", 32'(a_odata), 32'h0007);
`ifdef REG_ARB_MUX_PARITY_EN
    chk("post_rst_par", 32'(a_par), 32'h1);
`endif

    // five channels: out-of-range select, then wrap 4 -> 0
    a_valid = 8'h00;
    b_mode = 1'b0; b_sel = 3'd6; b_valid = 5'b11111;
    #1;
    chk("c5_sel6_ready", 32'(b_ready), 32'h0);
    step();
    chk("c5_sel6_valid", 32'(b_ovalid), 32'h0);
    b_mode = 1'b1; b_valid = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("c5_rr_ch",   32'(b_och),   (i % 2 == 0) ? 32'h0 : 32'h4);
      chk("c5_rr_data", 32'(b_odata), (i % 2 == 0) ? 32'hB000 : 32'hB004);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
